// File: rtl/mul_req_arbiter_ctrl.sv
// Two-requester round-robin controller for the repeated-addition multiplier datapath.
// Loads A and B, clears P, accumulates until eqz, then returns the product with a done pulse.
module mul_req_arbiter_ctrl #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         req1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] result,
  output logic         busy,
  output logic         ldA,
  output logic         ldB,
  output logic         ldP,
  output logic         clrP,
  output logic         decB,
  output logic [W-1:0] data_in,
  input  logic         eqz,
  input  logic [W-1:0] prod
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    ADD    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic         gnt_q, gnt_d;
  logic         last_q, last_d;
  logic [W-1:0] result_q, result_d;
  logic [W-1:0] data_in_q, data_in_d;
  logic         ld_a_q, ld_a_d;
  logic         ld_b_q, ld_b_d;
  logic         clr_p_q, clr_p_d;
  logic         busy_q, busy_d;
  logic         done0_q, done0_d;
  logic         done1_q, done1_d;

  // Next state, arbitration, and Moore outputs derived from the next state
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d   = (req0 && req1) ? ~last_q : req1;
          last_d  = gnt_d;
          state_d = LOAD_A;
        end
      end
      LOAD_A: state_d = LOAD_B;
      LOAD_B: state_d = ADD;
      ADD: begin
        if (eqz) begin
          result_d = prod;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ld_a_d  = (state_d == LOAD_A);
    ld_b_d  = (state_d == LOAD_B);
    clr_p_d = (state_d == LOAD_B);
    busy_d  = (state_d != IDLE);
    done0_d = (state_d == DONE) && !gnt_d;
    done1_d = (state_d == DONE) && gnt_d;
    if (state_d == LOAD_A)      data_in_d = gnt_d ? a1 : a0;
    else if (state_d == LOAD_B) data_in_d = gnt_d ? b1 : b0;
    else                        data_in_d = '0;
  end

  // last_q resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      result_q  <= '0;
      data_in_q <= '0;
      ld_a_q    <= 1'b0;
      ld_b_q    <= 1'b0;
      clr_p_q   <= 1'b0;
      busy_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      result_q  <= result_d;
      data_in_q <= data_in_d;
      ld_a_q    <= ld_a_d;
      ld_b_q    <= ld_b_d;
      clr_p_q   <= clr_p_d;
      busy_q    <= busy_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
    end
  end

  // Accumulate strobes are Mealy on eqz so the counter never decrements past zero
  assign ldP     = (state_q == ADD) && !eqz;
  assign decB    = (state_q == ADD) && !eqz;
  assign ldA     = ld_a_q;
  assign ldB     = ld_b_q;
  assign clrP    = clr_p_q;
  assign busy    = busy_q;
  assign done0   = done0_q;
  assign done1   = done1_q;
  assign result  = result_q;
  assign data_in = data_in_q;

endmodule

// File: tb/tb_mul_req_arbiter_ctrl.sv
// Directed bench for mul_req_arbiter_ctrl with a behavioural multiplier datapath attached.
module tb_mul_req_arbiter_ctrl;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         done0, done1, busy, ldA, ldB, ldP, clrP, decB, eqz;
  logic [W-1:0] result, data_in, prod;

  int vecs  = 0;
  int fails = 0;
  int cyc, pulses, bad;
  logic d0, d1;
  logic [W-1:0] ain, bin;

  always #5 clk = ~clk;

  mul_req_arbiter_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1), .result(result), .busy(busy),
    .ldA(ldA), .ldB(ldB), .ldP(ldP), .clrP(clrP), .decB(decB),
    .data_in(data_in), .eqz(eqz), .prod(prod)
  );

  // Datapath: no reset, A register, B down-counter, P accumulator
  logic [W-1:0] a_r = '0, b_r = '0, p_r = '0;
  always @(posedge clk) begin
    if (ldA) a_r <= data_in;
    if (ldB) b_r <= data_in;
    else if (decB) b_r <= b_r - 16'd1;
    if (clrP) p_r <= '0;
    else if (ldP) p_r <= p_r + a_r;
  end
  assign eqz  = (b_r == '0);
  assign prod = p_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts negedges until a done pulse, tallying strobes along the way
  task automatic wait_done(output int n, output logic o0, output logic o1, output int np,
                           output int nbad, output logic [W-1:0] oa, output logic [W-1:0] ob);
    n = 0; o0 = 1'b0; o1 = 1'b0; np = 0; nbad = 0; oa = '0; ob = '0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (ldP) np++;
      if ((ldB && decB) || (clrP && ldP)) nbad++;
      if (ldA) oa = data_in;
      if (ldB) ob = data_in;
      if (done0 || done1) begin
        o0 = done0; o1 = done1;
        break;
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_done", 32'({done0, done1}), 32'd0);
    chk("rst_strobes", 32'({ldA, ldB, ldP, clrP, decB}), 32'd0);
    chk("rst_data_in", 32'(data_in), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // 1: 7*5 on requester 0
    req0 = 1'b1; a0 = 16'd7; b0 = 16'd5;
    wait_done(cyc, d0, d1, pulses, bad, ain, bin);
    req0 = 1'b0;
    chk("t1_latency", 32'(cyc), 32'd9);
    chk("t1_done", 32'({d0, d1}), 32'b10);
    chk("t1_pulses", 32'(pulses), 32'd5);
    chk("t1_ain", 32'(ain), 32'd7);
    chk("t1_bin", 32'(bin), 32'd5);
    chk("t1_result", 32'(result), 32'd35);
    chk("t1_bad", 32'(bad), 32'd0);
    @(negedge clk);
    chk("t1_pulse_width", 32'({done0, done1}), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: b=0 on requester 1
    req1 = 1'b1; a1 = 16'd1234; b1 = 16'd0;
    wait_done(cyc, d0, d1, pulses, bad, ain, bin);
    req1 = 1'b0;
    chk("t2_latency", 32'(cyc), 32'd4);
    chk("t2_done", 32'({d0, d1}), 32'b01);
    chk("t2_pulses", 32'(pulses), 32'd0);
    chk("t2_result", 32'(result), 32'd0);
    @(negedge clk);

    // 3: simultaneous requests after reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a0 = 16'd3; b0 = 16'd4; a1 = 16'd10; b1 = 16'd3;
    req0 = 1'b1; req1 = 1'b1;
    wait_done(cyc, d0, d1, pulses, bad, ain, bin);
    req0 = 1'b0;
    chk("t3a_latency", 32'(cyc), 32'd8);
    chk("t3a_done", 32'({d0, d1}), 32'b10);
    chk("t3a_result", 32'(result), 32'd12);
    @(negedge clk);
    chk("t3a_idle", 32'(busy), 32'd0);
    wait_done(cyc, d0, d1, pulses, bad, ain, bin);
    req1 = 1'b0;
    chk("t3b_latency", 32'(cyc), 32'd7);
    chk("t3b_done", 32'({d0, d1}), 32'b01);
    chk("t3b_result", 32'(result), 32'd30);
    chk("t3b_ain", 32'(ain), 32'd10);
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1;
    wait_done(cyc, d0, d1, pulses, bad, ain, bin);
    req0 = 1'b0; req1 = 1'b0;
    chk("t3c_done", 32'({d0, d1}), 32'b10);
    chk("t3c_result", 32'(result), 32'd12);
    @(negedge clk);

    // 4: truncation mod 2^16
    req0 = 1'b1; a0 = 16'hFFFF; b0 = 16'd2;
    wait_done(cyc, d0, d1, pulses, bad, ain, bin);
    req0 = 1'b0;
    chk("t4a_latency", 32'(cyc), 32'd6);
    chk("t4a_result", 32'(result), 32'h0000_FFFE);
    @(negedge clk);
    req0 = 1'b1; a0 = 16'h4000; b0 = 16'd8;
    wait_done(cyc, d0, d1, pulses, bad, ain, bin);
    req0 = 1'b0;
    chk("t4b_latency", 32'(cyc), 32'd12);
    chk("t4b_pulses", 32'(pulses), 32'd8);
    chk("t4b_result", 32'(result), 32'h0000_0000);
    @(negedge clk);

    // 5: async reset in the 10th ADD cycle, then a clean operation
    req0 = 1'b1; a0 = 16'd100; b0 = 16'd50;
    repeat (12) @(negedge clk);
    chk("t5_busy_pre", 32'(busy), 32'd1);
    chk("t5_ldp_pre", 32'({ldP, decB}), 32'b11);
    #1 rst = 1'b1;
    #1;
    chk("t5_busy_rst", 32'(busy), 32'd0);
    chk("t5_strobes_rst", 32'({ldA, ldB, ldP, clrP, decB}), 32'd0);
    chk("t5_done_rst", 32'({done0, done1}), 32'd0);
    chk("t5_result_rst", 32'(result), 32'd0);
    @(negedge clk);
    rst = 1'b0; req0 = 1'b0;
    @(negedge clk);
    req1 = 1'b1; a1 = 16'd2; b1 = 16'd3;
    wait_done(cyc, d0, d1, pulses, bad, ain, bin);
    req1 = 1'b0;
    chk("t5_latency", 32'(cyc), 32'd7);
    chk("t5_done", 32'({d0, d1}), 32'b01);
    chk("t5_result", 32'(result), 32'd6);
    @(negedge clk);

    // 6: continuous requests from both alternate 0,1,0,1,...
    a0 = 16'd5; b0 = 16'd1; a1 = 16'd9; b1 = 16'd1;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_done(cyc, d0, d1, pulses, bad, ain, bin);
      if (i == 5) begin req0 = 1'b0; req1 = 1'b0; end
      chk($sformatf("t6_latency_%0d", i), 32'(cyc), 32'd5);
      chk($sformatf("t6_done_%0d", i), 32'({d0, d1}), (i % 2 == 0) ? 32'b10 : 32'b01);
      chk($sformatf("t6_result_%0d", i), 32'(result), (i % 2 == 0) ? 32'd5 : 32'd9);
      chk($sformatf("t6_bad_%0d", i), 32'(bad), 32'd0);
      @(negedge clk);
      chk($sformatf("t6_idle_%0d", i), 32'(busy), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule

// File: doc/mul_req_arbiter_ctrl.md
Name: mul_req_arbiter_ctrl

Overview:
- Sequences the repeated-addition multiplier datapath (A register, P accumulator, B down-counter, adder, zero detect) and shares it between two requesters.
- Round-robin arbitration picks one requester per operation.
- Drives the datapath load/clear/decrement strobes and the operand bus, watches eqz, and returns the product with a one-cycle done pulse.
- Sits between two client blocks and one datapath instance; the datapath itself has no reset and is unchanged.

Parameters:
W, 16, operand/product/bus width (matches datapath).

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
req0  in  1  requester 0 request; held high until done0 seen.
a0  in  W  requester 0 multiplicand; stable while req0 high.
b0  in  W  requester 0 multiplier; stable while req0 high.
req1  in  1  requester 1 request.
a1  in  W  requester 1 multiplicand.
b1  in  W  requester 1 multiplier.
done0  out  1  one-cycle pulse, result valid for requester 0.
done1  out  1  one-cycle pulse, result valid for requester 1.
result  out  W  registered product, holds until next completion.
busy  out  1  high in every state except IDLE.
ldA  out  1  datapath A load.
ldB  out  1  datapath B counter load.
ldP  out  1  datapath P load.
clrP  out  1  datapath P clear.
decB  out  1  datapath B decrement.
data_in  out  W  datapath operand bus.
eqz  in  1  datapath B==0 flag (combinational from registered counter).

Behaviour:
- Reset (async, any state):
  - state=IDLE, gnt_id=0, last_grant=1 (requester 0 wins first tie).
  - result=0, done0=done1=0.
  - All strobes 0, data_in=0.
- States: IDLE, LOAD_A, LOAD_B, ADD, DONE.
- IDLE:
  - If no req, stay.
  - If exactly one req, grant it.
  - If both, grant the requester != last_grant.
  - On grant: gnt_id <= winner, last_grant <= winner, go LOAD_A.
- LOAD_A: ldA=1, data_in=a[gnt_id]; next LOAD_B.
- LOAD_B: ldB=1, clrP=1, data_in=b[gnt_id]; next ADD.
- ADD:
  - ldP=decB=!eqz, combinational (Mealy on eqz).
  - If eqz=0, stay.
  - If eqz=1: result <= prod captured via P (controller input prod, W bits, from datapath P register), and go DONE.
- DONE: done[gnt_id]=1 (registered, exactly one cycle); next IDLE.
- Outside LOAD_A/LOAD_B, data_in=0. ldA/ldB/clrP are Moore outputs.
- Added port: prod in W, datapath P register value.
- Latency: from the IDLE edge that grants, done is high in cycle B+4 (LOAD_A, LOAD_B, B+1 ADD cycles, DONE). The ADD state issues exactly B ldP/decB pulses.
- Arithmetic: product is a*b mod 2^W; no overflow flag. decB is never issued with eqz=1, so the counter never wraps.
- Handshake:
  - Requester drops req on the edge ending DONE.
  - A req still high in the IDLE cycle after DONE is treated as a new request.
  - A req dropped mid-operation is ignored; the operation completes and done still pulses.
  - A req raised while busy waits.
- Fairness: under continuous requests from both, grants alternate 0,1,0,1.
- Reset mid-operation:
  - Sequence aborts; no done.
  - Stale datapath contents are harmless because every operation reloads A and B and clears P before ADD.
- Strobes are mutually consistent: never ldB with decB, never clrP with ldP.

Test Plan:
1. req0, a0=7, b0=5 -> LOAD_A, LOAD_B, 6 ADD cycles with 5 ldP/decB pulses; done0 high 9 cycles after grant edge, result=35, done1 never.
2. req1, a1=1234, b1=0 -> no ldP/decB pulses, done1 4 cycles after grant, result=0.
3. req0 and req1 rise together after reset (a0=3,b0=4; a1=10,b1=3) -> requester 0 first (result=12, done0), requester 1 next (result=30, done1); both again -> requester 0 wins.
4. a0=16'hFFFF, b0=2 -> result=16'hFFFE; a0=16'h4000, b0=8 -> result=16'h0000 (truncation).
5. req0 a0=100, b0=50; assert rst at 10th ADD cycle -> all strobes, done, busy, result go 0 asynchronously. Then req1 a1=2, b1=3 -> result=6 with no residue from the prior P.
6. req0 and req1 both held continuously for 6 operations (b=1 each) -> done pulses alternate 0,1,0,1,0,1, and no grant occurs within DONE.
